// File: rtl/ifu_lsu_icb_arb.sv
// ifu_lsu_icb_arb: two-requester ICB arbiter (IFU fetch, LSU load/store) onto one BIU port.
// Commands and responses pass combinationally. An in-order ID FIFO of OUTS_DEPTH entries
// routes each downstream response back to the requester that issued the command.
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin arbitration.
// Without it, arbitration is fixed priority with LSU over IFU.
module ifu_lsu_icb_arb #(
  parameter int unsigned OUTS_DEPTH = 2,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  // IFU command / response
  input  logic                ifu_icb_cmd_valid,
  output logic                ifu_icb_cmd_ready,
  input  logic [ADDR_W-1:0]   ifu_icb_cmd_addr,
  output logic                ifu_icb_rsp_valid,
  input  logic                ifu_icb_rsp_ready,
  output logic                ifu_icb_rsp_err,
  output logic [DATA_W-1:0]   ifu_icb_rsp_rdata,
  // LSU command / response
  input  logic                lsu_icb_cmd_valid,
  output logic                lsu_icb_cmd_ready,
  input  logic [ADDR_W-1:0]   lsu_icb_cmd_addr,
  input  logic                lsu_icb_cmd_read,
  input  logic [DATA_W-1:0]   lsu_icb_cmd_wdata,
  input  logic [DATA_W/8-1:0] lsu_icb_cmd_wmask,
  output logic                lsu_icb_rsp_valid,
  input  logic                lsu_icb_rsp_ready,
  output logic                lsu_icb_rsp_err,
  output logic [DATA_W-1:0]   lsu_icb_rsp_rdata,
  // Shared downstream BIU port
  output logic                biu_icb_cmd_valid,
  input  logic                biu_icb_cmd_ready,
  output logic [ADDR_W-1:0]   biu_icb_cmd_addr,
  output logic                biu_icb_cmd_read,
  output logic [DATA_W-1:0]   biu_icb_cmd_wdata,
  output logic [DATA_W/8-1:0] biu_icb_cmd_wmask,
  input  logic                biu_icb_rsp_valid,
  output logic                biu_icb_rsp_ready,
  input  logic                biu_icb_rsp_err,
  input  logic [DATA_W-1:0]   biu_icb_rsp_rdata,
  output logic                arb_idle
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(OUTS_DEPTH + 1);
  localparam int unsigned PTR_W  = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;

  // Grant lock: HOLD keeps the presented command stable until the BIU accepts it
  typedef enum logic [0:0] {ST_OPEN, ST_HOLD} state_e;

  state_e                  state_q, state_d;
  logic                    hold_sel_q, hold_sel_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PTR_W-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OUTS_DEPTH-1:0]   ids_q, ids_d;

  logic arb_sel;      // 0 = IFU, 1 = LSU
  logic sel_valid;
  logic fifo_full;
  logic fifo_empty;
  logic cmd_hsk;
  logic rsp_hsk;
  logic head_id;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTS_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_full  = (cnt_q == CNT_W'(OUTS_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign head_id    = ids_q[rptr_q];

  // Requester selection: a held grant wins; otherwise arbitrate between live requests
  always_comb begin
    arb_sel = lsu_icb_cmd_valid;
`ifdef ARB_ROUND_ROBIN_EN
    if (ifu_icb_cmd_valid && lsu_icb_cmd_valid) begin
      arb_sel = ~last_q;
    end
`endif
    if (state_q == ST_HOLD) begin
      arb_sel = hold_sel_q;
    end
  end

  // Command path: mux the granted payload to BIU; IFU is always a full-word read
  always_comb begin
    sel_valid         = arb_sel ? lsu_icb_cmd_valid : ifu_icb_cmd_valid;
    biu_icb_cmd_valid = sel_valid & ~fifo_full;
    biu_icb_cmd_addr  = arb_sel ? lsu_icb_cmd_addr  : ifu_icb_cmd_addr;
    biu_icb_cmd_read  = arb_sel ? lsu_icb_cmd_read  : 1'b1;
    biu_icb_cmd_wdata = arb_sel ? lsu_icb_cmd_wdata : '0;
    biu_icb_cmd_wmask = arb_sel ? lsu_icb_cmd_wmask : MASK_W'(0);
    ifu_icb_cmd_ready = ~arb_sel & biu_icb_cmd_ready & ~fifo_full;
    lsu_icb_cmd_ready =  arb_sel & biu_icb_cmd_ready & ~fifo_full;
    cmd_hsk           = biu_icb_cmd_valid & biu_icb_cmd_ready;
  end

  // Response path: route to the requester at the head of the ID FIFO
  always_comb begin
    biu_icb_rsp_ready = ~fifo_empty & (head_id ? lsu_icb_rsp_ready : ifu_icb_rsp_ready);
    ifu_icb_rsp_valid = ~fifo_empty & ~head_id & biu_icb_rsp_valid;
    lsu_icb_rsp_valid = ~fifo_empty &  head_id & biu_icb_rsp_valid;
    ifu_icb_rsp_err   = biu_icb_rsp_err;
    lsu_icb_rsp_err   = biu_icb_rsp_err;
    ifu_icb_rsp_rdata = biu_icb_rsp_rdata;
    lsu_icb_rsp_rdata = biu_icb_rsp_rdata;
    rsp_hsk           = biu_icb_rsp_valid & biu_icb_rsp_ready;
    arb_idle          = fifo_empty & ~ifu_icb_cmd_valid & ~lsu_icb_cmd_valid;
  end

  // Grant-lock next state: enter HOLD when a command is shown but not taken
  always_comb begin
    state_d    = state_q;
    hold_sel_d = hold_sel_q;
    case (state_q)
      ST_OPEN: begin
        if (biu_icb_cmd_valid && !biu_icb_cmd_ready) begin
          state_d    = ST_HOLD;
          hold_sel_d = arb_sel;
        end
      end
      ST_HOLD: begin
        // a withdrawn request also releases the lock so the other side cannot starve
        if (cmd_hsk || !sel_valid) begin
          state_d = ST_OPEN;
        end
      end
      default: state_d = ST_OPEN;
    endcase
  end

  // ID FIFO next state: push source on command handshake, pop on response handshake
  always_comb begin
    ids_d  = ids_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (cmd_hsk) begin
      ids_d[wptr_q] = arb_sel;
      wptr_d        = ptr_inc(wptr_q);
    end
    if (rsp_hsk) begin
      rptr_d = ptr_inc(rptr_q);
    end
    case ({cmd_hsk, rsp_hsk})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Round-robin pointer remembers the last requester actually accepted
  always_comb begin
    last_d = last_q;
    if (cmd_hsk) begin
      last_d = arb_sel;
    end
  end

  // Round-robin pointer register; reset as if LSU went last so IFU wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  // State registers; reset drops any outstanding IDs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OPEN;
      hold_sel_q <= 1'b0;
      cnt_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      ids_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_sel_q <= hold_sel_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ids_q      <= ids_d;
    end
  end

endmodule

// File: tb/tb_ifu_lsu_icb_arb.sv
// Scoreboard bench for ifu_lsu_icb_arb: stimulus pushes expected BIU commands and
// routed responses; a negedge monitor pops and compares on every handshake.
module tb_ifu_lsu_icb_arb;

  logic        clk;
  logic        rst_n;
  logic        ifu_icb_cmd_valid, ifu_icb_cmd_ready;
  logic [31:0] ifu_icb_cmd_addr;
  logic        ifu_icb_rsp_valid, ifu_icb_rsp_ready, ifu_icb_rsp_err;
  logic [31:0] ifu_icb_rsp_rdata;
  logic        lsu_icb_cmd_valid, lsu_icb_cmd_ready;
  logic [31:0] lsu_icb_cmd_addr;
  logic        lsu_icb_cmd_read;
  logic [31:0] lsu_icb_cmd_wdata;
  logic [3:0]  lsu_icb_cmd_wmask;
  logic        lsu_icb_rsp_valid, lsu_icb_rsp_ready, lsu_icb_rsp_err;
  logic [31:0] lsu_icb_rsp_rdata;
  logic        biu_icb_cmd_valid, biu_icb_cmd_ready;
  logic [31:0] biu_icb_cmd_addr;
  logic        biu_icb_cmd_read;
  logic [31:0] biu_icb_cmd_wdata;
  logic [3:0]  biu_icb_cmd_wmask;
  logic        biu_icb_rsp_valid, biu_icb_rsp_ready, biu_icb_rsp_err;
  logic [31:0] biu_icb_rsp_rdata;
  logic        arb_idle;

  ifu_lsu_icb_arb #(.OUTS_DEPTH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_icb_cmd_valid(ifu_icb_cmd_valid), .ifu_icb_cmd_ready(ifu_icb_cmd_ready),
    .ifu_icb_cmd_addr(ifu_icb_cmd_addr),
    .ifu_icb_rsp_valid(ifu_icb_rsp_valid), .ifu_icb_rsp_ready(ifu_icb_rsp_ready),
    .ifu_icb_rsp_err(ifu_icb_rsp_err), .ifu_icb_rsp_rdata(ifu_icb_rsp_rdata),
    .lsu_icb_cmd_valid(lsu_icb_cmd_valid), .lsu_icb_cmd_ready(lsu_icb_cmd_ready),
    .lsu_icb_cmd_addr(lsu_icb_cmd_addr), .lsu_icb_cmd_read(lsu_icb_cmd_read),
    .lsu_icb_cmd_wdata(lsu_icb_cmd_wdata), .lsu_icb_cmd_wmask(lsu_icb_cmd_wmask),
    .lsu_icb_rsp_valid(lsu_icb_rsp_valid), .lsu_icb_rsp_ready(lsu_icb_rsp_ready),
    .lsu_icb_rsp_err(lsu_icb_rsp_err), .lsu_icb_rsp_rdata(lsu_icb_rsp_rdata),
    .biu_icb_cmd_valid(biu_icb_cmd_valid), .biu_icb_cmd_ready(biu_icb_cmd_ready),
    .biu_icb_cmd_addr(biu_icb_cmd_addr), .biu_icb_cmd_read(biu_icb_cmd_read),
    .biu_icb_cmd_wdata(biu_icb_cmd_wdata), .biu_icb_cmd_wmask(biu_icb_cmd_wmask),
    .biu_icb_rsp_valid(biu_icb_rsp_valid), .biu_icb_rsp_ready(biu_icb_rsp_ready),
    .biu_icb_rsp_err(biu_icb_rsp_err), .biu_icb_rsp_rdata(biu_icb_rsp_rdata),
    .arb_idle(arb_idle)
  );

  typedef struct packed {
    logic        src;   // 0 = IFU, 1 = LSU
    logic [31:0] addr;
    logic        read;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } cmd_t;

  typedef struct packed {
    logic        dst;   // 0 = IFU, 1 = LSU
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  cmd_t cq[$];
  rsp_t rq[$];
  int   n_vec;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: compare every BIU command and response handshake against the queues
  cmd_t ec;
  rsp_t er;
  always @(negedge clk) begin
    if (rst_n) begin
      if (biu_icb_cmd_valid && biu_icb_cmd_ready) begin
        if (cq.size() == 0) begin
          check("cmd_unexpected", 64'd1, 64'd0);
        end else begin
          ec = cq.pop_front();
          check("cmd_lsu_ready", 64'(lsu_icb_cmd_ready), 64'(ec.src));
          check("cmd_ifu_ready", 64'(ifu_icb_cmd_ready), 64'(!ec.src));
          check("cmd_addr", 64'(biu_icb_cmd_addr), 64'(ec.addr));
          check("cmd_read", 64'(biu_icb_cmd_read), 64'(ec.read));
          check("cmd_wdata", 64'(biu_icb_cmd_wdata), 64'(ec.wdata));
          check("cmd_wmask", 64'(biu_icb_cmd_wmask), 64'(ec.wmask));
        end
      end
      if (biu_icb_rsp_valid && biu_icb_rsp_ready) begin
        if (rq.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          er = rq.pop_front();
          check("rsp_lsu_valid", 64'(lsu_icb_rsp_valid), 64'(er.dst));
          check("rsp_ifu_valid", 64'(ifu_icb_rsp_valid), 64'(!er.dst));
          check("rsp_rdata", 64'(er.dst ? lsu_icb_rsp_rdata : ifu_icb_rsp_rdata), 64'(er.rdata));
          check("rsp_err", 64'(er.dst ? lsu_icb_rsp_err : ifu_icb_rsp_err), 64'(er.err));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_ifu(input logic [31:0] addr);
    cq.push_back('{src: 1'b0, addr: addr, read: 1'b1, wdata: 32'h0, wmask: 4'h0});
  endtask

  task automatic exp_lsu(input logic [31:0] addr, input logic rd, input logic [31:0] wd, input logic [3:0] wm);
    cq.push_back('{src: 1'b1, addr: addr, read: rd, wdata: wd, wmask: wm});
  endtask

  task automatic exp_rsp(input logic dst, input logic [31:0] rdata, input logic err);
    rq.push_back('{dst: dst, rdata: rdata, err: err});
  endtask

  task automatic drive_idle();
    ifu_icb_cmd_valid = 1'b0; ifu_icb_cmd_addr = '0; ifu_icb_rsp_ready = 1'b1;
    lsu_icb_cmd_valid = 1'b0; lsu_icb_cmd_addr = '0; lsu_icb_cmd_read = 1'b1;
    lsu_icb_cmd_wdata = '0;   lsu_icb_cmd_wmask = '0; lsu_icb_rsp_ready = 1'b1;
    biu_icb_cmd_ready = 1'b0; biu_icb_rsp_valid = 1'b0; biu_icb_rsp_err = 1'b0;
    biu_icb_rsp_rdata = '0;
  endtask

  logic g;

  initial begin
    n_vec = 0;
    n_err = 0;
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    // reset state
    check("rst_arb_idle", 64'(arb_idle), 64'd1);
    check("rst_biu_cmd_valid", 64'(biu_icb_cmd_valid), 64'd0);
    check("rst_biu_rsp_ready", 64'(biu_icb_rsp_ready), 64'd0);
    check("rst_ifu_cmd_ready", 64'(ifu_icb_cmd_ready), 64'd0);
    check("rst_lsu_cmd_ready", 64'(lsu_icb_cmd_ready), 64'd0);
    check("rst_rsp_valids", 64'({ifu_icb_rsp_valid, lsu_icb_rsp_valid}), 64'd0);
    step();

    // both request every cycle; each response pops the previous command
    ifu_icb_cmd_valid = 1'b1; ifu_icb_cmd_addr = 32'h0000_0100;
    lsu_icb_cmd_valid = 1'b1; lsu_icb_cmd_addr = 32'h0000_2000;
    lsu_icb_cmd_read = 1'b0;  lsu_icb_cmd_wdata = 32'h1111_2222; lsu_icb_cmd_wmask = 4'hF;
    biu_icb_cmd_ready = 1'b1; biu_icb_rsp_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      g = (k % 2) == 1;
`else
      g = 1'b1;
`endif
      biu_icb_rsp_rdata = 32'hA000_0000 + 32'(k);
      if (g) exp_lsu(32'h0000_2000, 1'b0, 32'h1111_2222, 4'hF);
      else   exp_ifu(32'h0000_0100);
      exp_rsp(g, 32'hA000_0000 + 32'(k + 1), 1'b0);
      step();
    end
    ifu_icb_cmd_valid = 1'b0; lsu_icb_cmd_valid = 1'b0;
    biu_icb_rsp_rdata = 32'hA000_0004;
    step();
    biu_icb_rsp_valid = 1'b0; biu_icb_cmd_ready = 1'b0;
    #1 check("rr_drained_idle", 64'(arb_idle), 64'd1);
    step();

    // LSU stalled three cycles; IFU arrives mid-stall and must wait
    lsu_icb_cmd_valid = 1'b1; lsu_icb_cmd_addr = 32'h0000_1000; lsu_icb_cmd_read = 1'b0;
    lsu_icb_cmd_wdata = 32'hCAFE_F00D; lsu_icb_cmd_wmask = 4'h3;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        ifu_icb_cmd_valid = 1'b1; ifu_icb_cmd_addr = 32'h0000_0200;
      end
      #1;
      check("hold_valid", 64'(biu_icb_cmd_valid), 64'd1);
      check("hold_addr", 64'(biu_icb_cmd_addr), 64'h1000);
      check("hold_wdata", 64'(biu_icb_cmd_wdata), 64'hCAFE_F00D);
      check("hold_readies", 64'({ifu_icb_cmd_ready, lsu_icb_cmd_ready}), 64'd0);
      step();
    end
    biu_icb_cmd_ready = 1'b1;
    exp_lsu(32'h0000_1000, 1'b0, 32'hCAFE_F00D, 4'h3);
    step();
    lsu_icb_cmd_valid = 1'b0;
    exp_ifu(32'h0000_0200);
    step();
    ifu_icb_cmd_valid = 1'b0; biu_icb_cmd_ready = 1'b0;
    biu_icb_rsp_valid = 1'b1; biu_icb_rsp_rdata = 32'hBBBB_0001;
    exp_rsp(1'b1, 32'hBBBB_0001, 1'b0);
    step();
    biu_icb_rsp_rdata = 32'hBBBB_0002;
    exp_rsp(1'b0, 32'hBBBB_0002, 1'b0);
    step();
    biu_icb_rsp_valid = 1'b0;
    step();

    // fill to OUTS_DEPTH, third command blocked, then in-order routing
    biu_icb_cmd_ready = 1'b1;
    ifu_icb_cmd_valid = 1'b1; ifu_icb_cmd_addr = 32'h0000_0300;
    exp_ifu(32'h0000_0300);
    step();
    ifu_icb_cmd_valid = 1'b0;
    lsu_icb_cmd_valid = 1'b1; lsu_icb_cmd_addr = 32'h0000_0400; lsu_icb_cmd_read = 1'b1;
    lsu_icb_cmd_wdata = '0; lsu_icb_cmd_wmask = '0;
    exp_lsu(32'h0000_0400, 1'b1, 32'h0, 4'h0);
    step();
    lsu_icb_cmd_valid = 1'b0;
    ifu_icb_cmd_valid = 1'b1; ifu_icb_cmd_addr = 32'h0000_0500;
    #1;
    check("full_cmd_valid", 64'(biu_icb_cmd_valid), 64'd0);
    check("full_ifu_ready", 64'(ifu_icb_cmd_ready), 64'd0);
    check("full_not_idle", 64'(arb_idle), 64'd0);
    step();
    biu_icb_rsp_valid = 1'b1; biu_icb_rsp_rdata = 32'hDEAD_BEEF;
    exp_rsp(1'b0, 32'hDEAD_BEEF, 1'b0);
    #1;
    check("pop_cycle_cmd_valid", 64'(biu_icb_cmd_valid), 64'd0);
    check("pop_cycle_ifu_rsp_valid", 64'(ifu_icb_rsp_valid), 64'd1);
    check("pop_cycle_lsu_rsp_valid", 64'(lsu_icb_rsp_valid), 64'd0);
    step();
    biu_icb_rsp_rdata = 32'h1234_5678;
    exp_rsp(1'b1, 32'h1234_5678, 1'b0);
    exp_ifu(32'h0000_0500);
    #1 check("after_pop_cmd_valid", 64'(biu_icb_cmd_valid), 64'd1);
    step();
    ifu_icb_cmd_valid = 1'b0;
    biu_icb_rsp_rdata = 32'h55AA_55AA; biu_icb_rsp_err = 1'b1;
    exp_rsp(1'b0, 32'h55AA_55AA, 1'b1);
    step();
    biu_icb_rsp_valid = 1'b0; biu_icb_rsp_err = 1'b0; biu_icb_cmd_ready = 1'b0;
    #1 check("full_drained_idle", 64'(arb_idle), 64'd1);
    step();

    // reset with two outstanding discards them
    biu_icb_cmd_ready = 1'b1;
    ifu_icb_cmd_valid = 1'b1; ifu_icb_cmd_addr = 32'h0000_0600;
    exp_ifu(32'h0000_0600);
    step();
    ifu_icb_cmd_valid = 1'b0;
    lsu_icb_cmd_valid = 1'b1; lsu_icb_cmd_addr = 32'h0000_0700; lsu_icb_cmd_read = 1'b0;
    lsu_icb_cmd_wdata = 32'h0000_0077; lsu_icb_cmd_wmask = 4'h1;
    exp_lsu(32'h0000_0700, 1'b0, 32'h0000_0077, 4'h1);
    step();
    lsu_icb_cmd_valid = 1'b0; biu_icb_cmd_ready = 1'b0;
    #1 check("pre_reset_busy", 64'(arb_idle), 64'd0);
    rst_n = 1'b0;
    #1 check("in_reset_idle", 64'(arb_idle), 64'd1);
    step();
    rst_n = 1'b1;
    biu_icb_rsp_valid = 1'b1; biu_icb_rsp_rdata = 32'hBAD0_BAD0;
    #1;
    check("post_reset_rsp_ready", 64'(biu_icb_rsp_ready), 64'd0);
    check("post_reset_rsp_valids", 64'({ifu_icb_rsp_valid, lsu_icb_rsp_valid}), 64'd0);
    check("post_reset_idle", 64'(arb_idle), 64'd1);
    step();
    step();
    biu_icb_rsp_valid = 1'b0;
    step();

    check("cmd_queue_drained", 64'(cq.size()), 64'd0);
    check("rsp_queue_drained", 64'(rq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
